// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48A1 MAC sequencer: FSM states, term tags
// and the OPMODE words that drive the slice's X/Z multiplexers.
package dsp_pkg;

    // OPMODE words (Z in bits 3:2, X in bits 1:0; bits 7:4 always zero).
    localparam logic [7:0] OPM_MUL   = 8'h01;  // X=M, Z=0
    localparam logic [7:0] OPM_MAC   = 8'h09;  // X=M, Z=P
    localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P (P holds)
    localparam logic [7:0] OPM_RESET = 8'h00;  // shown while the slice is cleared

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TAG_HOLD  = 2'd0,
        TAG_FIRST = 2'd1,
        TAG_ACC   = 2'd2
    } tag_t;

    // Map a term tag onto the OPMODE word the slice needs for it.
    function automatic logic [7:0] tag_to_opmode(input tag_t tag);
        logic [7:0] opm;
        case (tag)
            TAG_FIRST: opm = OPM_MUL;
            TAG_ACC:   opm = OPM_MAC;
            default:   opm = OPM_HOLD;
        endcase
        return opm;
    endfunction

endpackage

// File: rtl/dsp_tag_delay.sv
// Shift register that delays the term tag so its OPMODE reaches the slice
// in step with the operands passing through the A1/B1 register stage.
module dsp_tag_delay
    import dsp_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic srst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    logic [DEPTH-1:0][1:0] stage_q;
    logic [DEPTH-1:0][1:0] stage_d;

    // Next value of every stage: new tag enters stage 0, the rest shift up.
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; after reset every stage reads as HOLD.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= TAG_HOLD;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = tag_t'(stage_q[DEPTH-1]);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as an unsigned 18x18 dot-product engine: takes
// LEN operand pairs over valid/ready, issues them with the matching OPMODE,
// waits out the slice pipeline and returns P with a one-cycle valid pulse.
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int OPM_DLY  = 1,
    parameter int PIPE_LAT = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] LEN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [17:0]      IN_A,
    input  logic [17:0]      IN_B,
    output logic [17:0]      DSP_A,
    output logic [17:0]      DSP_B,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CE,
    output logic             DSP_RST,
    input  logic [47:0]      DSP_P,
    output logic             BUSY,
    output logic [47:0]      RESULT,
    output logic             RESULT_VALID
);

    localparam int LAT_W = $clog2(PIPE_LAT + 1);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic               first_q,  first_d;
    logic [LAT_W-1:0]   drain_q,  drain_d;
    logic [17:0]        a_q,      a_d;
    logic [17:0]        b_q,      b_d;
    tag_t               tag_q,    tag_d;
    logic [47:0]        result_q, result_d;
    logic               dsp_rst_q, dsp_rst_d;
    tag_t               tag_dly;
    logic               handshake;

    assign handshake = (state_q == ST_ISSUE) && IN_VALID;

    // Next-state logic: job control, operand capture, tagging and readback.
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        first_d   = first_q;
        drain_d   = drain_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = TAG_HOLD;
        result_d  = result_q;
        dsp_rst_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (LEN == '0) begin
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        remain_d  = LEN;
                        first_d   = 1'b1;
                        dsp_rst_d = 1'b1;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    a_d      = IN_A;
                    b_d      = IN_B;
                    tag_d    = first_q ? TAG_FIRST : TAG_ACC;
                    first_d  = 1'b0;
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        drain_d = LAT_W'(PIPE_LAT);
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Wait until the last term has left the P register.
                if (drain_q == '0) begin
                    result_d = DSP_P;
                    state_d  = ST_DONE;
                end else begin
                    drain_d = drain_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset also holds the slice in reset one cycle longer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            remain_q  <= '0;
            first_q   <= 1'b0;
            drain_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= TAG_HOLD;
            result_q  <= '0;
            dsp_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            first_q   <= first_d;
            drain_q   <= drain_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            dsp_rst_q <= dsp_rst_d;
        end
    end

    dsp_tag_delay #(
        .DEPTH (OPM_DLY)
    ) u_tag_delay (
        .clk     (CLK),
        .srst    (RST),
        .tag_in  (tag_q),
        .tag_out (tag_dly)
    );

    assign IN_READY     = (state_q == ST_ISSUE);
    assign BUSY         = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign RESULT_VALID = (state_q == ST_DONE);
    assign RESULT       = result_q;
    assign DSP_A        = a_q;
    assign DSP_B        = b_q;
    assign DSP_CE       = 1'b1;
    assign DSP_RST      = RST || dsp_rst_q;
    assign DSP_OPMODE   = dsp_rst_q ? OPM_RESET : tag_to_opmode(tag_dly);

endmodule
